tl_fifo_arbiter_2to1: RTL and testbench

- Two-requester TileLink-UL arbiter that shares one FIFO-ordered A/D port, the port presented by the FIFO-fixer/monitor stage, between two clients.
- Round-robin arbitration on the A channel, with the grant held for every beat of a multi-beat message.
- Grant order is recorded in an ownership FIFO, and D responses are steered back to the owning requester in that order.
- Sits between two client crossbar ports and the downstream FIFO-fixed slave path.

---
 rtl/tl_fifo_arbiter_2to1_if.sv | 19 +
 rtl/tl_fifo_arbiter_2to1.sv | 134 +++++++++++++
 tb/tb_tl_fifo_arbiter_2to1.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_fifo_arbiter_2to1_if.sv
// TileLink-UL A/D channel bundle. The master drives A and accepts D; the slave does the reverse.
interface tl_fifo_arbiter_2to1_if;
  logic         a_valid;
  logic         a_ready;
  logic [110:0] a_bits;   // {opcode[2:0], size[3:0], address[31:0], mask[7:0], data[63:0]}
  logic         d_valid;
  logic         d_ready;
  logic [72:0]  d_bits;   // {opcode[2:0], size[3:0], denied, corrupt, data[63:0]}

  modport master (
    output a_valid, a_bits, d_ready,
    input  a_ready, d_valid, d_bits
  );

  modport slave (
    input  a_valid, a_bits, d_ready,
    output a_ready, d_valid, d_bits
  );
endinterface

// File: rtl/tl_fifo_arbiter_2to1.sv
// Two-client TileLink-UL arbiter onto one FIFO-ordered A/D port. Round-robin A grants are held
// for a whole burst, and D responses are returned to owners in grant order via an ownership FIFO.
module tl_fifo_arbiter_2to1 #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BEAT_LOG2       = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  tl_fifo_arbiter_2to1_if.slave         in0,
  tl_fifo_arbiter_2to1_if.slave         in1,
  tl_fifo_arbiter_2to1_if.master        out,
  output logic                          err_unexpected_d
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = 16 - BEAT_LOG2;
  localparam logic [CntW-1:0] One = CntW'(1);

  function automatic logic [CntW-1:0] beats_of(input logic burst_op, input logic [3:0] size);
    if (burst_op && (size > 4'(BEAT_LOG2))) return One << (size - 4'(BEAT_LOG2));
    return One;
  endfunction

  logic            lock_q, lock_id_q, prio_q;
  logic [CntW-1:0] a_left_q;
  logic            d_busy_q;
  logic [CntW-1:0] d_left_q;
  logic            fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            err_q;

  logic            sel, sel_valid, gate, full, empty, head;
  logic            a_fire, a_last, push, d_fire, d_last, pop;
  logic [2:0]      a_op;
  logic [CntW-1:0] a_beats, d_beats;

  always_comb begin
    if (lock_q) begin
      sel = lock_id_q;
    end else if (in0.a_valid && in1.a_valid) begin
      sel = prio_q;
    end else begin
      sel = in1.a_valid;
    end
  end

  assign full      = (count_q == (PtrW+1)'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign sel_valid = sel ? in1.a_valid : in0.a_valid;
  // Only a first beat needs a free ownership slot; pops this cycle do not count.
  assign gate      = !lock_q && full;

  assign out.a_valid = !reset && !gate && sel_valid;
  assign out.a_bits  = sel ? in1.a_bits : in0.a_bits;
  assign in0.a_ready = !reset && !gate && !sel && out.a_ready;
  assign in1.a_ready = !reset && !gate && sel && out.a_ready;

  assign a_fire  = out.a_valid && out.a_ready;
  assign a_op    = out.a_bits[110:108];
  assign a_beats = beats_of((a_op == 3'd0) || (a_op == 3'd1), out.a_bits[107:104]);
  assign a_last  = lock_q ? (a_left_q == One) : (a_beats == One);
  assign push    = a_fire && !lock_q;

  assign head        = fifo_q[rd_ptr_q];
  assign out.d_ready = !reset && !empty && (head ? in1.d_ready : in0.d_ready);
  assign in0.d_valid = !reset && !empty && !head && out.d_valid;
  assign in1.d_valid = !reset && !empty && head && out.d_valid;
  assign in0.d_bits  = out.d_bits;
  assign in1.d_bits  = out.d_bits;

  assign d_fire  = out.d_valid && out.d_ready;
  assign d_beats = beats_of(out.d_bits[72:70] == 3'd1, out.d_bits[69:66]);
  assign d_last  = d_busy_q ? (d_left_q == One) : (d_beats == One);
  assign pop     = d_fire && d_last;

  assign err_unexpected_d = err_q;

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      prio_q    <= 1'b0;
      a_left_q  <= '0;
      d_busy_q  <= 1'b0;
      d_left_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (a_fire) begin
        if (!lock_q) begin
          if (!a_last) begin
            lock_q    <= 1'b1;
            lock_id_q <= sel;
            a_left_q  <= a_beats - One;
          end
        end else begin
          a_left_q <= a_left_q - One;
          if (a_last) lock_q <= 1'b0;
        end
        if (a_last) prio_q <= !sel;
      end

      if (d_fire) begin
        if (!d_busy_q) begin
          if (!d_last) begin
            d_busy_q <= 1'b1;
            d_left_q <= d_beats - One;
          end
        end else begin
          d_left_q <= d_left_q - One;
          if (d_last) d_busy_q <= 1'b0;
        end
      end

      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PtrW+1)'(1);
      end

      if (out.d_valid && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_fifo_arbiter_2to1.sv
// Bench for tl_fifo_arbiter_2to1: directed A-side checks plus a D-side scoreboard of owner/data.
module tb_tl_fifo_arbiter_2to1;

  logic clock = 1'b0;
  logic reset;
  logic err;

  always #5 clock = ~clock;

  tl_fifo_arbiter_2to1_if in0_if ();
  tl_fifo_arbiter_2to1_if in1_if ();
  tl_fifo_arbiter_2to1_if out_if ();

  tl_fifo_arbiter_2to1 #(
    .MAX_OUTSTANDING(4),
    .BEAT_LOG2      (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in0             (in0_if),
    .in1             (in1_if),
    .out             (out_if),
    .err_unexpected_d(err)
  );

  typedef struct {
    logic        owner;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [110:0] mk_a(input logic [2:0] op, input logic [3:0] size,
                                        input logic [31:0] addr, input logic [63:0] data);
    return {op, size, addr, 8'hff, data};
  endfunction

  function automatic logic [72:0] mk_d(input logic [2:0] op, input logic [3:0] size,
                                       input logic [63:0] data);
    return {op, size, 1'b0, 1'b0, data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_pop(input logic who, input logic [63:0] data);
    exp_t e;
    check("d_sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("d_owner", who, e.owner);
      check("d_data", data, e.data);
    end
  endtask

  // D monitor: every delivered beat must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (in0_if.d_valid || in1_if.d_valid)
        check("d_valid_onehot", in0_if.d_valid && in1_if.d_valid, 1'b0);
      if (in0_if.d_valid && in0_if.d_ready) sb_pop(1'b0, in0_if.d_bits[63:0]);
      if (in1_if.d_valid && in1_if.d_ready) sb_pop(1'b1, in1_if.d_bits[63:0]);
    end
  end

  task automatic idle_inputs();
    in0_if.a_valid = 1'b0;
    in1_if.a_valid = 1'b0;
    in0_if.a_bits  = '0;
    in1_if.a_bits  = '0;
    in0_if.d_ready = 1'b1;
    in1_if.d_ready = 1'b1;
    out_if.a_ready = 1'b1;
    out_if.d_valid = 1'b0;
    out_if.d_bits  = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic d_send(input logic owner, input logic [2:0] op, input logic [3:0] size,
                        input logic [63:0] data, input int beats);
    logic ok;
    for (int i = 0; i < beats; i++) begin
      out_if.d_valid = 1'b1;
      out_if.d_bits  = mk_d(op, size, data + 64'(i));
      exp_q.push_back('{owner, data + 64'(i)});
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge clock);
        if (out_if.d_ready) ok = 1'b1;
        tick();
      end
      if (!ok) check("d_accept_timeout", ok, 1'b1);
    end
    out_if.d_valid = 1'b0;
  endtask

  logic [110:0] b0, b1;
  logic         rdy, pushed;
  int           beat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live inputs: every valid/ready output held low.
    reset = 1'b1;
    idle_inputs();
    in0_if.a_valid = 1'b1;
    in0_if.a_bits  = mk_a(3'd4, 4'd3, 32'h100, 64'h0);
    out_if.d_valid = 1'b1;
    tick();
    @(negedge clock);
    check("rst_out_a_valid", out_if.a_valid, 1'b0);
    check("rst_in0_a_ready", in0_if.a_ready, 1'b0);
    check("rst_out_d_ready", out_if.d_ready, 1'b0);
    check("rst_in0_d_valid", in0_if.d_valid, 1'b0);
    idle_inputs();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_err", err, 1'b0);
    check("rst_empty_d_ready", out_if.d_ready, 1'b0);
    tick();

    // Basic Get from in0.
    apply_reset();
    b0 = mk_a(3'd4, 4'd3, 32'h1000, 64'h0);
    in0_if.a_valid = 1'b1;
    in0_if.a_bits  = b0;
    @(negedge clock);
    check("get_out_a_valid", out_if.a_valid, 1'b1);
    check("get_in0_a_ready", in0_if.a_ready, 1'b1);
    check("get_out_a_bits", out_if.a_bits, b0);
    tick();
    in0_if.a_valid = 1'b0;
    tick();
    d_send(1'b0, 3'd1, 4'd3, 64'hA0A0_0000_0000_0001, 1);
    @(negedge clock);
    check("get_empty_after", out_if.d_ready, 1'b0);
    tick();

    // Contention: round-robin in0, in1, in0, in1, then full.
    apply_reset();
    b0 = mk_a(3'd4, 4'd3, 32'h1000, 64'h0);
    b1 = mk_a(3'd4, 4'd3, 32'h2000, 64'h0);
    in0_if.a_valid = 1'b1;
    in0_if.a_bits  = b0;
    in1_if.a_valid = 1'b1;
    in1_if.a_bits  = b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rr_in0_a_ready", in0_if.a_ready, (k % 2) == 0);
      check("rr_in1_a_ready", in1_if.a_ready, (k % 2) == 1);
      check("rr_out_a_bits", out_if.a_bits, ((k % 2) == 1) ? b1 : b0);
      tick();
    end
    @(negedge clock);
    check("rr_full_out_a_valid", out_if.a_valid, 1'b0);
    check("rr_full_in0_a_ready", in0_if.a_ready, 1'b0);
    check("rr_full_in1_a_ready", in1_if.a_ready, 1'b0);
    tick();
    in0_if.a_valid = 1'b0;
    in1_if.a_valid = 1'b0;
    for (int k = 0; k < 4; k++) d_send(1'(k % 2), 3'd1, 4'd3, 64'hC000 + 64'(k * 16), 1);

    // Burst lock: in1 4-beat PutFullData while in0 stays valid.
    apply_reset();
    b0 = mk_a(3'd4, 4'd3, 32'h1000, 64'h0);
    in1_if.a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in1_if.a_bits = mk_a(3'd0, 4'd5, 32'h2000, 64'hB0 + 64'(k));
      @(negedge clock);
      check("lock_in1_a_ready", in1_if.a_ready, 1'b1);
      check("lock_in0_a_ready", in0_if.a_ready, 1'b0);
      check("lock_out_a_bits", out_if.a_bits, in1_if.a_bits);
      tick();
      in0_if.a_valid = 1'b1;
      in0_if.a_bits  = b0;
    end
    in1_if.a_valid = 1'b0;
    @(negedge clock);
    check("unlock_in0_a_ready", in0_if.a_ready, 1'b1);
    check("unlock_out_a_bits", out_if.a_bits, b0);
    tick();
    in0_if.a_valid = 1'b0;
    d_send(1'b1, 3'd0, 4'd5, 64'hACC1, 1);
    d_send(1'b0, 3'd1, 4'd3, 64'hACC0, 1);

    // Full FIFO, then pop and push attempt in the same cycle.
    apply_reset();
    in0_if.a_valid = 1'b1;
    in0_if.a_bits  = mk_a(3'd4, 4'd3, 32'h3000, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("fill_in0_a_ready", in0_if.a_ready, 1'b1);
      tick();
    end
    @(negedge clock);
    check("full_in0_a_ready", in0_if.a_ready, 1'b0);
    check("full_out_a_valid", out_if.a_valid, 1'b0);
    tick();
    out_if.d_valid = 1'b1;
    out_if.d_bits  = mk_d(3'd1, 4'd3, 64'hF000);
    exp_q.push_back('{1'b0, 64'hF000});
    @(negedge clock);
    check("full_pop_d_ready", out_if.d_ready, 1'b1);
    check("full_pop_in0_a_ready", in0_if.a_ready, 1'b0);
    tick();
    out_if.d_valid = 1'b0;
    @(negedge clock);
    check("after_pop_in0_a_ready", in0_if.a_ready, 1'b1);
    tick();
    in0_if.a_valid = 1'b0;
    for (int k = 1; k < 5; k++) d_send(1'b0, 3'd1, 4'd3, 64'hF000 + 64'(k), 1);
    @(negedge clock);
    check("full_drained", out_if.d_ready, 1'b0);
    tick();

    // Multi-beat D (8 beats) with toggling in0_d_ready.
    apply_reset();
    in0_if.a_valid = 1'b1;
    in0_if.a_bits  = mk_a(3'd4, 4'd6, 32'h4000, 64'h0);
    @(negedge clock);
    check("md_in0_a_ready", in0_if.a_ready, 1'b1);
    tick();
    in0_if.a_valid = 1'b0;
    beat   = 0;
    pushed = 1'b0;
    for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
      rdy            = cyc[0];
      in0_if.d_ready = rdy;
      out_if.d_valid = 1'b1;
      out_if.d_bits  = mk_d(3'd1, 4'd6, 64'hD500 + 64'(beat));
      if (!pushed) begin
        exp_q.push_back('{1'b0, 64'hD500 + 64'(beat)});
        pushed = 1'b1;
      end
      @(negedge clock);
      check("md_out_d_ready", out_if.d_ready, rdy);
      check("md_in0_d_valid", in0_if.d_valid, 1'b1);
      if (rdy) begin
        beat++;
        pushed = 1'b0;
      end
      tick();
    end
    out_if.d_valid = 1'b0;
    in0_if.d_ready = 1'b1;
    @(negedge clock);
    check("md_popped", out_if.d_ready, 1'b0);
    tick();

    // Unexpected D while empty: sticky error until reset.
    apply_reset();
    out_if.d_valid = 1'b1;
    out_if.d_bits  = mk_d(3'd1, 4'd3, 64'hBAD);
    @(negedge clock);
    check("ud_out_d_ready", out_if.d_ready, 1'b0);
    check("ud_in0_d_valid", in0_if.d_valid, 1'b0);
    check("ud_in1_d_valid", in1_if.d_valid, 1'b0);
    check("ud_err_same_cycle", err, 1'b0);
    tick();
    out_if.d_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("ud_err_sticky", err, 1'b1);
      tick();
    end
    apply_reset();
    @(negedge clock);
    check("ud_err_cleared", err, 1'b0);
    tick();

    check("sb_drained", exp_q.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
